// File: rtl/riscv_enc_pkg.sv
// Opcode/format tables shared by the encoder and its FIFO: op_e, fmt_e,
// major opcodes, funct3/funct7 lookup and the queued entry layout.
package riscv_enc_pkg;

  typedef enum logic [5:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU,
    OP_ADDW, OP_SUBW, OP_SLLW, OP_SRLW, OP_SRAW,
    OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADDIW, OP_SLLIW, OP_SRLIW, OP_SRAIW,
    OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU,
    OP_SB, OP_SH, OP_SW, OP_SD,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR
  } op_e;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;

  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;

  localparam logic [6:0] F7_ALT = 7'b0100000;
  localparam logic [6:0] F7_MUL = 7'b0000001;

  typedef struct packed {
    logic       legal;
    fmt_e       fmt;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       shift;
    logic       wshift;
  } op_info_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] addr;
    logic        err;
  } enc_entry_t;

  localparam int ENTRY_W = $bits(enc_entry_t);

  function automatic op_info_t op_info(input op_e op);
    op_info_t i;
    i = '0;
    i.legal = 1'b1;
    case (op) inside
      [OP_ADD:OP_REMU]:    begin i.fmt = FMT_R; i.opcode = OPC_OP;      end
      [OP_ADDW:OP_REMUW]:  begin i.fmt = FMT_R; i.opcode = OPC_OP32;    end
      [OP_ADDI:OP_SRAI]:   begin i.fmt = FMT_I; i.opcode = OPC_OPIMM;   end
      [OP_ADDIW:OP_SRAIW]: begin i.fmt = FMT_I; i.opcode = OPC_OPIMM32; end
      [OP_LB:OP_LWU]:      begin i.fmt = FMT_I; i.opcode = OPC_LOAD;    end
      [OP_SB:OP_SD]:       begin i.fmt = FMT_S; i.opcode = OPC_STORE;   end
      [OP_BEQ:OP_BGEU]:    begin i.fmt = FMT_B; i.opcode = OPC_BRANCH;  end
      OP_LUI:              begin i.fmt = FMT_U; i.opcode = OPC_LUI;     end
      OP_AUIPC:            begin i.fmt = FMT_U; i.opcode = OPC_AUIPC;   end
      OP_JAL:              begin i.fmt = FMT_J; i.opcode = OPC_JAL;     end
      OP_JALR:             begin i.fmt = FMT_I; i.opcode = OPC_JALR;    end
      default:             i.legal = 1'b0;
    endcase
    case (op)
      OP_SUB, OP_SUBW:                 i.funct7 = F7_ALT;
      OP_SLL, OP_SLLW:                 i.funct3 = 3'd1;
      OP_SLT, OP_SLTI, OP_LW, OP_SW:   i.funct3 = 3'd2;
      OP_SLTU, OP_SLTIU, OP_LD, OP_SD: i.funct3 = 3'd3;
      OP_XOR, OP_XORI, OP_LBU:         i.funct3 = 3'd4;
      OP_SRL, OP_SRLW, OP_LHU:         i.funct3 = 3'd5;
      OP_SRA, OP_SRAW:                 begin i.funct3 = 3'd5; i.funct7 = F7_ALT; end
      OP_OR, OP_ORI, OP_LWU:           i.funct3 = 3'd6;
      OP_AND, OP_ANDI:                 i.funct3 = 3'd7;
      OP_MUL, OP_MULW:                 i.funct7 = F7_MUL;
      OP_MULH:                         begin i.funct3 = 3'd1; i.funct7 = F7_MUL; end
      OP_MULHSU:                       begin i.funct3 = 3'd2; i.funct7 = F7_MUL; end
      OP_MULHU:                        begin i.funct3 = 3'd3; i.funct7 = F7_MUL; end
      OP_DIV, OP_DIVW:                 begin i.funct3 = 3'd4; i.funct7 = F7_MUL; end
      OP_DIVU, OP_DIVUW:               begin i.funct3 = 3'd5; i.funct7 = F7_MUL; end
      OP_REM, OP_REMW:                 begin i.funct3 = 3'd6; i.funct7 = F7_MUL; end
      OP_REMU, OP_REMUW:               begin i.funct3 = 3'd7; i.funct7 = F7_MUL; end
      OP_SLLI:                         begin i.funct3 = 3'd1; i.shift = 1'b1; end
      OP_SRLI:                         begin i.funct3 = 3'd5; i.shift = 1'b1; end
      OP_SRAI:                         begin i.funct3 = 3'd5; i.shift = 1'b1; i.funct7 = F7_ALT; end
      OP_SLLIW:                        begin i.funct3 = 3'd1; i.shift = 1'b1; i.wshift = 1'b1; end
      OP_SRLIW:                        begin i.funct3 = 3'd5; i.shift = 1'b1; i.wshift = 1'b1; end
      OP_SRAIW:                        begin i.funct3 = 3'd5; i.shift = 1'b1; i.wshift = 1'b1; i.funct7 = F7_ALT; end
      OP_LH, OP_SH, OP_BNE:            i.funct3 = 3'd1;
      OP_BLT:                          i.funct3 = 3'd4;
      OP_BGE:                          i.funct3 = 3'd5;
      OP_BLTU:                         i.funct3 = 3'd6;
      OP_BGEU:                         i.funct3 = 3'd7;
      default:                         i.funct3 = 3'd0;
    endcase
    return i;
  endfunction

endpackage

// File: rtl/riscv_instr_encoder_fifo.sv
// DEPTH-entry output queue of encoded words; head is zero when empty.
// Never overflows because the encoder only accepts against free credit.
module enc_fifo
  import riscv_enc_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_data,
  input  logic               pop,
  output logic [ENTRY_W-1:0] head,
  output logic               head_valid,
  output logic [CW-1:0]      count
);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) mem[wr_ptr] <= push_data;
  end

  assign head_valid = (count != '0);
  assign head       = head_valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/riscv_instr_encoder.sv
// Packs decoded RV64IM fields into 32-bit words: S1 register, S2 format/check/tag, then FIFO (2-cycle latency).
// in_ready is credit based: FIFO occupancy plus in-flight stages must stay below DEPTH.
module riscv_instr_encoder
  import riscv_enc_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [63:0] BASE_ADDR = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_op,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [63:0] out_addr,
  output logic        out_err,
  output logic [31:0] enc_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic        s1_vld;
  logic [5:0]  s1_op;
  logic [4:0]  s1_rd, s1_rs1, s1_rs2;
  logic [31:0] s1_imm;
  logic        s2_vld;
  enc_entry_t  s2_entry;
  logic [63:0] next_addr;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   used;
  logic [ENTRY_W-1:0] fifo_head;
  enc_entry_t  head_e;
  op_info_t    info;
  logic [31:0] word;
  logic        bad;
  logic        accept;

  assign used     = {1'b0, fifo_count} + {{CW{1'b0}}, s1_vld} + {{CW{1'b0}}, s2_vld};
  assign in_ready = !reset && (used < (CW+1)'(DEPTH));
  assign accept   = in_valid && in_ready;

  always_comb begin
    info = op_info(op_e'(s1_op));
    word = '0;
    bad  = ~info.legal;
    case (info.fmt)
      FMT_R: word = {info.funct7, s1_rs2, s1_rs1, info.funct3, s1_rd, info.opcode};
      FMT_I: begin
        if (info.shift) begin
          // shamt lives in [25:20]; the top six bits carry the SRAI/SRAIW bit 30
          word = {info.funct7[6:1], s1_imm[5:0], s1_rs1, info.funct3, s1_rd, info.opcode};
          bad  = bad | (info.wshift ? (s1_imm[31:5] != '0) : (s1_imm[31:6] != '0));
        end else begin
          word = {s1_imm[11:0], s1_rs1, info.funct3, s1_rd, info.opcode};
          bad  = bad | !((&s1_imm[31:11]) || !(|s1_imm[31:11]));
        end
      end
      FMT_S: begin
        word = {s1_imm[11:5], s1_rs2, s1_rs1, info.funct3, s1_imm[4:0], info.opcode};
        bad  = bad | !((&s1_imm[31:11]) || !(|s1_imm[31:11]));
      end
      FMT_B: begin
        word = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, info.funct3, s1_imm[4:1], s1_imm[11], info.opcode};
        bad  = bad | s1_imm[0] | !((&s1_imm[31:12]) || !(|s1_imm[31:12]));
      end
      FMT_U: begin
        word = {s1_imm[31:12], s1_rd, info.opcode};
        bad  = bad | (s1_imm[11:0] != '0);
      end
      FMT_J: begin
        word = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_rd, info.opcode};
        bad  = bad | s1_imm[0] | !((&s1_imm[31:20]) || !(|s1_imm[31:20]));
      end
      default: bad = 1'b1;
    endcase
    if (bad) word = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld    <= 1'b0;
      s1_op     <= '0;
      s1_rd     <= '0;
      s1_rs1    <= '0;
      s1_rs2    <= '0;
      s1_imm    <= '0;
      s2_vld    <= 1'b0;
      s2_entry  <= '0;
      next_addr <= BASE_ADDR;
      enc_count <= '0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_op     <= in_op;
        s1_rd     <= in_rd;
        s1_rs1    <= in_rs1;
        s1_rs2    <= in_rs2;
        s1_imm    <= in_imm;
        enc_count <= enc_count + 32'd1;
      end
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_entry.instr <= word;
        s2_entry.addr  <= next_addr;
        s2_entry.err   <= bad;
        next_addr      <= next_addr + 64'd4;
      end
    end
  end

  enc_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (s2_vld),
    .push_data  (s2_entry),
    .pop        (out_valid && out_ready),
    .head       (fifo_head),
    .head_valid (out_valid),
    .count      (fifo_count)
  );

  assign head_e    = fifo_head;
  assign out_instr = head_e.instr;
  assign out_addr  = head_e.addr;
  assign out_err   = head_e.err;

endmodule

// File: tb/tb_riscv_instr_encoder.sv
// Scoreboard bench for riscv_instr_encoder; BASE_ADDR near 2^64 so the address wrap is exercised.
module tb_riscv_instr_encoder;
  import riscv_enc_pkg::*;

  localparam logic [63:0] TB_BASE = 64'hFFFF_FFFF_FFFF_FFF8;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] addr;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  in_op = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [63:0] out_addr;
  logic        out_err;
  logic [31:0] enc_count;

  exp_t        exp_q[$];
  logic [63:0] exp_addr = TB_BASE;
  int          exp_count = 0;
  int          checks = 0;
  int          errors = 0;

  riscv_instr_encoder #(.DEPTH(4), .BASE_ADDR(TB_BASE)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .out_err   (out_err),
    .enc_count (enc_count)
  );

  always #5 clk = ~clk;

  // Scoreboard: every word the consumer takes is checked against the oldest expectation.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output instr=%h addr=%h err=%0b, none expected", out_instr, out_addr, out_err);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (out_instr !== e.instr || out_addr !== e.addr || out_err !== e.err) begin
          errors++;
          $display("FAIL scoreboard got instr=%h addr=%h err=%0b expected instr=%h addr=%h err=%0b",
                   out_instr, out_addr, out_err, e.instr, e.addr, e.err);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm,
                      input logic [31:0] exp_instr, input logic exp_err);
    int n;
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout in_ready=%0b expected 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    exp_q.push_back('{exp_instr, exp_addr, exp_err});
    exp_addr = exp_addr + 64'd4;
    exp_count++;
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d expected 0", exp_q.size());
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty out_valid=%0b expected 0", out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%0b expected 0", in_ready); end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got=%0b expected 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_addr !== 64'h0 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs valid=%0b instr=%h addr=%h err=%0b expected all 0", out_valid, out_instr, out_addr, out_err);
    end
    checks++;
    if (enc_count !== 32'd0) begin errors++; $display("FAIL reset_enc_count got=%0d expected 0", enc_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, 1'b0);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_n0 out_valid=%0b expected 0", out_valid); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_n1 out_valid=%0b expected 0", out_valid); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_instr !== 32'h00500093 || out_addr !== TB_BASE) begin
      errors++;
      $display("FAIL latency_n2 valid=%0b instr=%h addr=%h expected 1 00500093 %h", out_valid, out_instr, out_addr, TB_BASE);
    end
    @(posedge clk); #1;
    wait_drain();
  endtask

  task automatic test_back_to_back();
    send(OP_ADD,  5'd3, 5'd1, 5'd2, 32'hDEADBEEF, 32'h002081B3, 1'b0);
    send(OP_SD,   5'd0, 5'd1, 5'd2, 32'd8,        32'h0020B423, 1'b0);
    send(OP_MUL,  5'd3, 5'd1, 5'd2, 32'd0,        32'h022081B3, 1'b0);
    send(OP_SRAI, 5'd1, 5'd2, 5'd0, 32'd63,       32'h43F15093, 1'b0);
    send(OP_JAL,  5'd1, 5'd0, 5'd0, 32'd8,        32'h008000EF, 1'b0);
    wait_drain();
    checks++;
    if (enc_count !== 32'(exp_count)) begin errors++; $display("FAIL b2b_enc_count got=%0d expected %0d", enc_count, exp_count); end
  endtask

  task automatic test_branch_lui();
    send(OP_BEQ,  5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 32'hFE208EE3, 1'b0);
    send(OP_LUI,  5'd5, 5'd0, 5'd0, 32'h12345000, 32'h123452B7, 1'b0);
    send(OP_JAL,  5'd1, 5'd0, 5'd0, 32'd2048,     32'h001000EF, 1'b0);
    send(OP_SW,   5'd0, 5'd2, 5'd3, 32'hFFFFFFFF, 32'hFE312FA3, 1'b0);
    send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'hFFFFF800, 32'h80000093, 1'b0);
    send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd2047,     32'h7FF00093, 1'b0);
    send(OP_SLLIW,5'd1, 5'd2, 5'd0, 32'd31,       32'h01F1109B, 1'b0);
    send(OP_SLLI, 5'd1, 5'd2, 5'd0, 32'd63,       32'h03F11093, 1'b0);
    wait_drain();
  endtask

  task automatic test_errors();
    send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd4096,     32'h0, 1'b1);
    send(OP_BEQ,  5'd0, 5'd1, 5'd2, 32'd3,        32'h0, 1'b1);
    send(OP_SLLIW,5'd1, 5'd2, 5'd0, 32'd32,       32'h0, 1'b1);
    send(OP_LUI,  5'd5, 5'd0, 5'd0, 32'h12345001, 32'h0, 1'b1);
    send(6'd62,   5'd1, 5'd1, 5'd1, 32'd0,        32'h0, 1'b1);
    send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd2048,     32'h0, 1'b1);
    send(OP_SLLI, 5'd1, 5'd2, 5'd0, 32'd64,       32'h0, 1'b1);
    wait_drain();
  endtask

  task automatic test_backpressure();
    int accepts;
    logic r;
    accepts = 0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = OP_ADDI; in_rd = 5'd1; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 32'd0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      if (r) begin
        exp_q.push_back('{(32'(accepts) << 20) | 32'h93, exp_addr, 1'b0});
        exp_addr = exp_addr + 64'd4;
        exp_count++;
        accepts++;
      end
      #1 in_imm = 32'(accepts);
    end
    @(negedge clk);
    checks++;
    if (accepts != 4) begin errors++; $display("FAIL bp_accepts got=%0d expected 4", accepts); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got=%0b expected 0", in_ready); end
    checks++;
    if (out_valid !== 1'b1 || out_instr !== 32'h00000093) begin
      errors++;
      $display("FAIL bp_head_hold valid=%0b instr=%h expected 1 00000093", out_valid, out_instr);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_after got=%0b expected 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd1, 32'h00100093, 1'b0);
    send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd2, 32'h00200093, 1'b0);
    send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd3, 32'h00300093, 1'b0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    exp_q.delete();
    exp_addr = TB_BASE;
    exp_count = 0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_out_valid got=%0b expected 0", out_valid); end
    checks++;
    if (enc_count !== 32'd0) begin errors++; $display("FAIL mid_reset_enc_count got=%0d expected 0", enc_count); end
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_no_partial out_valid=%0b expected 0", out_valid); end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd7, 32'h00700093, 1'b0);
    wait_drain();
    checks++;
    if (enc_count !== 32'd1) begin errors++; $display("FAIL mid_reset_count_after got=%0d expected 1", enc_count); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_branch_lui();
    test_errors();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
